// File: rtl/fp16_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fp16_mul_pipe
// Brief   : 3-stage pipelined IEEE-754 half-precision multiplier, truncating,
//           flush-to-zero, valid/ready handshake with a "last" sideband.
// Rev     : 1.0  initial release
// ============================================================================
module fp16_mul_pipe #(
    parameter int FTZ     = 1,
    parameter int SAT_INF = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        out_last,
    output logic        busy
);

    localparam logic [14:0] C_INF = 15'h7C00;
    localparam logic [14:0] C_MAX = 15'h7BFF;

    logic              w_en;

    logic [4:0]        w_ea_f, w_eb_f;
    logic [4:0]        w_ea, w_eb;
    logic [10:0]       w_ma, w_mb;
    logic signed [6:0] w_es;
    logic              w_special, w_zero;

    logic              r_v1, r_sign1, r_special1, r_zero1, r_last1;
    logic [10:0]       r_ma1, r_mb1;
    logic signed [6:0] r_es1;

    logic              r_v2, r_sign2, r_special2, r_zero2, r_last2;
    logic [21:0]       r_prod2;
    logic signed [6:0] r_es2;

    logic              r_v3, r_last3;
    logic [15:0]       r_p3;

    logic [9:0]        w_man;
    logic signed [6:0] w_es_n;
    logic [15:0]       w_p;

    // The whole pipe moves as one; it only stalls when the output is blocked.
    assign w_en      = !r_v3 || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_v3;
    assign out_p     = r_p3;
    assign out_last  = r_last3;
    assign busy      = r_v1 || r_v2 || r_v3;

    assign w_ea_f    = in_a[14:10];
    assign w_eb_f    = in_b[14:10];
    assign w_ea      = (w_ea_f == 5'd0) ? 5'd1 : w_ea_f;
    assign w_eb      = (w_eb_f == 5'd0) ? 5'd1 : w_eb_f;
    assign w_ma      = {(w_ea_f != 5'd0), in_a[9:0]};
    assign w_mb      = {(w_eb_f != 5'd0), in_b[9:0]};
    assign w_es      = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 7'sd15;
    assign w_special = (w_ea_f == 5'd31) || (w_eb_f == 5'd31);
    assign w_zero    = ((w_ea_f == 5'd0) && (in_a[9:0] == 10'd0)) ||
                       ((w_eb_f == 5'd0) && (in_b[9:0] == 10'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1       <= 1'b0;
            r_sign1    <= 1'b0;
            r_special1 <= 1'b0;
            r_zero1    <= 1'b0;
            r_last1    <= 1'b0;
            r_ma1      <= '0;
            r_mb1      <= '0;
            r_es1      <= '0;
        end else if (w_en) begin
            r_v1       <= in_valid;
            r_sign1    <= in_a[15] ^ in_b[15];
            r_special1 <= w_special;
            r_zero1    <= w_zero;
            r_last1    <= in_last;
            r_ma1      <= w_ma;
            r_mb1      <= w_mb;
            r_es1      <= w_es;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2       <= 1'b0;
            r_sign2    <= 1'b0;
            r_special2 <= 1'b0;
            r_zero2    <= 1'b0;
            r_last2    <= 1'b0;
            r_prod2    <= '0;
            r_es2      <= '0;
        end else if (w_en) begin
            r_v2       <= r_v1;
            r_sign2    <= r_sign1;
            r_special2 <= r_special1;
            r_zero2    <= r_zero1;
            r_last2    <= r_last1;
            r_prod2    <= 22'(r_ma1) * 22'(r_mb1);
            r_es2      <= r_es1;
        end
    end

    // Leading-one search over bits 21..10; the highest set bit fixes both the
    // mantissa window and the exponent adjustment (bit 20 is the unit position).
    always_comb begin
        w_man  = '0;
        w_es_n = r_es2 - 7'sd10;
        for (int i = 10; i <= 21; i++) begin
            if (r_prod2[i]) begin
                w_man  = r_prod2[i-1 -: 10];
                w_es_n = r_es2 + $signed(7'(i - 20));
            end
        end
    end

    always_comb begin
        w_p = {r_sign2, 15'h0000};
        if (r_special2 && !r_zero2) begin
            w_p = {r_sign2, C_INF};
        end else if (r_zero2 || (r_prod2 == 22'd0)) begin
            w_p = {r_sign2, 15'h0000};
        end else if ((FTZ != 0) && (w_es_n <= 7'sd0)) begin
            w_p = {r_sign2, 15'h0000};
        end else if (w_es_n >= 7'sd31) begin
            w_p = {r_sign2, (SAT_INF != 0) ? C_INF : C_MAX};
        end else begin
            w_p = {r_sign2, w_es_n[4:0], w_man};
        end
    end

    // Bubbles leave the output register untouched so out_p only changes on real data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3    <= 1'b0;
            r_last3 <= 1'b0;
            r_p3    <= '0;
        end else if (w_en) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_p3    <= w_p;
                r_last3 <= r_last2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp16_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp16_mul_pipe
// Brief   : Scoreboard bench for fp16_mul_pipe (saturating and clamping builds).
// Rev     : 1.0  initial release
// ============================================================================
module tb_fp16_mul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;

    logic        in_ready, out_valid, out_last, busy;
    logic [15:0] out_p;
    logic        c_in_ready, c_out_valid, c_out_last, c_busy;
    logic [15:0] c_out_p;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] p_inf;
        logic [15:0] p_sat;
        logic        last;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fp16_mul_pipe #(.FTZ(1), .SAT_INF(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p), .out_last(out_last), .busy(busy)
    );

    fp16_mul_pipe #(.FTZ(1), .SAT_INF(0)) dut_clamp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_p(c_out_p), .out_last(c_out_last), .busy(c_busy)
    );

    // Reference: exact integer product, normalised on its leading one, truncated.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input bit sat_inf);
        logic s;
        int   ea, eb, ma, mb, p, k, be, m;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if ((ea == 0 && a[9:0] == 10'd0) || (eb == 0 && b[9:0] == 10'd0)) return {s, 15'h0000};
        if (ea == 31 || eb == 31) return {s, 15'h7C00};
        ma = (ea == 0) ? int'(a[9:0]) : int'(a[9:0]) + 1024;
        mb = (eb == 0) ? int'(b[9:0]) : int'(b[9:0]) + 1024;
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        p = ma * mb;
        k = 0;
        for (int i = 0; i < 22; i++) if (p[i]) k = i;
        be = k + ea + eb - 35;
        if (be <= 0) return {s, 15'h0000};
        if (be >= 31) return sat_inf ? {s, 15'h7C00} : {s, 15'h7BFF};
        m = (k >= 10) ? (p >> (k - 10)) : (p << (10 - k));
        return {s, be[4:0], m[9:0]};
    endfunction

    task automatic tick(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic l, input logic r, output bit in_fire, output bit out_fire);
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_last   = l;
        out_ready = r;
        #1;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (in_fire) sb.push_back('{ref_mul(a, b, 1'b1), ref_mul(a, b, 1'b0), l});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({out_valid, busy, out_p, out_last, c_out_valid, c_busy} !== 21'd0) begin
            bad++;
            $display("FAIL reset_state: got v=%b busy=%b p=%h last=%b, want all zero", out_valid, busy, out_p, out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({in_ready, c_in_ready, out_valid, busy} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b v=%b busy=%b, want rdy=1 v=0 busy=0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_latency();
        bit   fi, fo;
        int   lat;
        exp_t e;
        lat = -1;
        tick(1'b1, 16'h3C00, 16'h3C00, 1'b0, 1'b1, fi, fo);
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, fi, fo);
            if (fo) begin
                lat = c;
                e = sb.pop_front();
                total++;
                if (out_p !== e.p_inf || out_p !== 16'h3C00) begin
                    bad++;
                    $display("FAIL one_x_one: got %h want %h", out_p, 16'h3C00);
                end
            end
        end
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_arith();
        logic [15:0] ta[10] = '{16'h4000, 16'h3E00, 16'h7BFF, 16'h0400, 16'h8400,
                                16'h7C00, 16'h0001, 16'h3555, 16'h0200, 16'hFBFF};
        logic [15:0] tb[10] = '{16'hC200, 16'h3E00, 16'h4000, 16'h0400, 16'h0400,
                                16'h0000, 16'h3C00, 16'h4248, 16'h6000, 16'h3C01};
        bit   fi, fo;
        int   idx;
        exp_t e;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            tick(idx < 10, ta[idx % 10], tb[idx % 10], 1'b0, 1'b1, fi, fo);
            if (fi) idx++;
            if (fo) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL arith_out: unexpected output p=%h", out_p);
                end else begin
                    e = sb.pop_front();
                    if ({c_out_valid, out_p, c_out_p, out_last} !== {1'b1, e.p_inf, e.p_sat, e.last}) begin
                        bad++;
                        $display("FAIL arith_out: got p=%h clamp=%h last=%b want p=%h clamp=%h last=%b",
                                 out_p, c_out_p, out_last, e.p_inf, e.p_sat, e.last);
                    end
                end
            end
            if (idx == 10 && sb.size() == 0) break;
        end
        total++;
        if (idx != 10 || sb.size() != 0) begin
            bad++;
            $display("FAIL arith_drain: sent %0d pending %0d want sent 10 pending 0", idx, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta[5] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'hC500};
        logic [15:0] tb[5] = '{16'h4100, 16'h4100, 16'h3800, 16'h4400, 16'h3E00};
        bit   fi, fo;
        int   sent, got;
        exp_t e;
        sent = 0;
        got  = 0;
        for (int c = 0; c < 6; c++) begin
            tick(sent < 5, ta[sent % 5], tb[sent % 5], 1'b0, 1'b0, fi, fo);
            if (fi) sent++;
        end
        total++;
        if (sent != 3 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_accept: got accepted=%0d rdy=%b v=%b want 3 0 1", sent, in_ready, out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, ta[sent % 5], tb[sent % 5], 1'b0, 1'b0, fi, fo);
            total++;
            if (fi || out_valid !== 1'b1 || out_p !== sb[0].p_inf) begin
                bad++;
                $display("FAIL stall_hold: got p=%h v=%b acc=%b want p=%h v=1 acc=0", out_p, out_valid, fi, sb[0].p_inf);
            end
        end
        for (int c = 0; c < 30; c++) begin
            tick(sent < 5, ta[sent % 5], tb[sent % 5], 1'b0, 1'b1, fi, fo);
            if (fi) sent++;
            if (fo) begin
                got++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_out: unexpected output p=%h", out_p);
                end else begin
                    e = sb.pop_front();
                    if ({c_out_valid, out_p, c_out_p} !== {1'b1, e.p_inf, e.p_sat}) begin
                        bad++;
                        $display("FAIL b2b_out: got p=%h clamp=%h want p=%h clamp=%h", out_p, c_out_p, e.p_inf, e.p_sat);
                    end
                end
            end
            if (sent == 5 && sb.size() == 0) break;
        end
        total++;
        if (got != 5) begin
            bad++;
            $display("FAIL b2b_count: got %0d outputs want 5", got);
        end
    endtask

    task automatic test_last();
        logic [15:0] ta[4] = '{16'h3C00, 16'h7C00, 16'h3800, 16'h4400};
        logic [15:0] tb[4] = '{16'h4000, 16'h0000, 16'h3800, 16'hC000};
        bit   fi, fo;
        int   idx, got, last_at, nlast;
        exp_t e;
        idx = 0; got = 0; last_at = -1; nlast = 0;
        for (int c = 0; c < 20; c++) begin
            tick(idx < 4, ta[idx % 4], tb[idx % 4], idx == 3, 1'b1, fi, fo);
            if (fi) idx++;
            if (fo) begin
                if (out_last) begin nlast++; last_at = got; end
                got++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL last_out: unexpected output p=%h", out_p);
                end else begin
                    e = sb.pop_front();
                    if ({out_p, c_out_p, out_last, c_out_last} !== {e.p_inf, e.p_sat, e.last, e.last}) begin
                        bad++;
                        $display("FAIL last_out: got p=%h last=%b want p=%h last=%b", out_p, out_last, e.p_inf, e.last);
                    end
                end
            end
            if (idx == 4 && sb.size() == 0) break;
        end
        total++;
        if (nlast != 1 || last_at != 3) begin
            bad++;
            $display("FAIL last_position: got count=%0d at=%0d want count=1 at=3", nlast, last_at);
        end
    endtask

    task automatic test_random();
        bit   fi, fo;
        exp_t e;
        for (int c = 0; c < 460; c++) begin
            if (c < 400)
                tick(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom),
                     $urandom_range(0, 3) != 0, fi, fo);
            else
                tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, fi, fo);
            if (fo) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL rand_out: unexpected output p=%h", out_p);
                end else begin
                    e = sb.pop_front();
                    if ({c_out_valid, out_p, c_out_p, out_last} !== {1'b1, e.p_inf, e.p_sat, e.last}) begin
                        bad++;
                        $display("FAIL rand_out: got p=%h clamp=%h last=%b want p=%h clamp=%h last=%b",
                                 out_p, c_out_p, out_last, e.p_inf, e.p_sat, e.last);
                    end
                end
            end
            if (c >= 400 && sb.size() == 0) break;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL rand_drain: %0d results never emerged", sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        bit   fi, fo;
        int   outs, lat;
        exp_t e;
        outs = 0;
        lat  = -1;
        for (int c = 0; c < 3; c++) tick(1'b1, 16'h4200, 16'h4200, 1'b0, 1'b1, fi, fo);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        total++;
        if ({out_valid, busy, c_out_valid, c_busy} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_flush: got v=%b busy=%b want 0 0", out_valid, busy);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, fi, fo);
            if (out_valid || busy) outs++;
        end
        total++;
        if (outs != 0) begin
            bad++;
            $display("FAIL rst_stale: got %0d stale cycles want 0", outs);
        end
        tick(1'b1, 16'h4000, 16'h4200, 1'b0, 1'b1, fi, fo);
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, fi, fo);
            if (fo) begin
                lat = c;
                e = sb.pop_front();
                total++;
                if (out_p !== e.p_inf || out_p !== 16'h4600) begin
                    bad++;
                    $display("FAIL rst_resume: got %h want %h", out_p, 16'h4600);
                end
            end
        end
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL rst_latency: got %0d want 3", lat);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arith();
        test_back_to_back();
        test_last();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
